// File: rtl/lsu_copy_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_copy_engine : memory-port block copier (ascending word moves).       |
// | Optional word fill under LSU_COPY_FILL_EN.  Rev 1.0                      |
// +--------------------------------------------------------------------------+
module lsu_copy_engine #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_src,
  input  logic [31:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
`ifdef LSU_COPY_FILL_EN
  input  logic             i_fill,
  input  logic [31:0]      i_pattern,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LEN_W-1:0] o_count,
  output logic             o_re,
  output logic             o_we,
  output logic [31:0]      o_addr,
  output logic [31:0]      o_wdata,
  input  logic [31:0]      i_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_data;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] r_count;
  logic             r_err;
  logic             w_fill_cmd;
  logic             r_fill;
  logic [31:0]      w_pattern;
  logic             w_misalign;

`ifdef LSU_COPY_FILL_EN
  assign w_fill_cmd = i_fill;
  assign w_pattern  = i_pattern;

  always_ff @(posedge clk) begin
    if (rst)
      r_fill <= 1'b0;
    else if (r_state == S_IDLE && i_start)
      r_fill <= i_fill;
  end
`else
  assign w_fill_cmd = 1'b0;
  assign w_pattern  = 32'h0;
  assign r_fill     = 1'b0;
`endif

  // A fill never reads, so only the destination alignment matters for it.
  assign w_misalign = (|i_dst[1:0]) | (~w_fill_cmd & (|i_src[1:0]));

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_misalign || i_len == '0)
            w_next = S_DONE;
          else if (w_fill_cmd)
            w_next = S_WRITE;
          else
            w_next = S_READ;
        end
      end
      S_READ:  w_next = i_abort ? S_DONE : S_WRITE;
      S_WRITE: begin
        if (i_abort || r_rem == LEN_W'(1))
          w_next = S_DONE;
        else if (r_fill)
          w_next = S_WRITE;
        else
          w_next = S_READ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src   <= 32'h0;
      r_dst   <= 32'h0;
      r_data  <= 32'h0;
      r_rem   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src   <= i_src;
            r_dst   <= i_dst;
            r_rem   <= i_len;
            r_count <= '0;
            r_err   <= w_misalign;
            r_data  <= w_pattern;
          end
        end
        S_READ: begin
          // An aborted read is simply dropped; nothing gets written.
          if (i_abort) begin
            r_err <= 1'b1;
          end else begin
            r_data <= i_rdata;
            r_src  <= r_src + 32'd4;
          end
        end
        S_WRITE: begin
          r_dst   <= r_dst + 32'd4;
          r_count <= r_count + LEN_W'(1);
          r_rem   <= r_rem - LEN_W'(1);
          if (i_abort)
            r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_re    = 1'b0;
    o_we    = 1'b0;
    o_addr  = 32'h0;
    o_wdata = 32'h0;
    case (r_state)
      S_READ: begin
        o_re   = 1'b1;
        o_addr = r_src;
      end
      S_WRITE: begin
        o_we    = 1'b1;
        o_addr  = r_dst;
        o_wdata = r_data;
      end
      default: ;
    endcase
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);
  assign o_err   = (r_state == S_DONE) & r_err;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_lsu_copy_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu_copy_engine : directed bench with a small RAM + LED memory map.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_lsu_copy_engine;
  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic             i_abort;
  logic [31:0]      i_src;
  logic [31:0]      i_dst;
  logic [LEN_W-1:0] i_len;
  logic             o_busy;
  logic             o_done;
  logic             o_err;
  logic [LEN_W-1:0] o_count;
  logic             o_re;
  logic             o_we;
  logic [31:0]      o_addr;
  logic [31:0]      o_wdata;
  logic [31:0]      i_rdata;
`ifdef LSU_COPY_FILL_EN
  logic             i_fill;
  logic [31:0]      i_pattern;
`endif

  logic [31:0] ram [0:2047];
  logic [31:0] led_red;
  logic        tb_wr;
  logic [10:0] tb_idx;
  logic [31:0] tb_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .i_src     (i_src),
    .i_dst     (i_dst),
    .i_len     (i_len),
`ifdef LSU_COPY_FILL_EN
    .i_fill    (i_fill),
    .i_pattern (i_pattern),
`endif
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_count   (o_count),
    .o_re      (o_re),
    .o_we      (o_we),
    .o_addr    (o_addr),
    .o_wdata   (o_wdata),
    .i_rdata   (i_rdata)
  );

  // Data RAM at 0x2000-0x3FFF, LED red register at 0x7000.
  assign i_rdata = (o_addr[31:13] == 19'd1) ? ram[o_addr[12:2]] : 32'h0;

  always @(posedge clk) begin
    if (tb_wr)
      ram[tb_idx] <= tb_data;
    else if (o_we) begin
      if (o_addr[31:13] == 19'd1)
        ram[o_addr[12:2]] <= o_wdata;
      else if (o_addr == 32'h0000_7000)
        led_red <= o_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    tb_wr   = 1'b1;
    tb_idx  = addr[12:2];
    tb_data = data;
    tick();
    tb_wr   = 1'b0;
  endtask

  function automatic logic [31:0] peek(input logic [31:0] addr);
    logic [10:0] idx;
    idx = addr[12:2];
    return ram[idx];
  endfunction

  // abort_kind: 0 none, 1 abort on the abort_n-th READ, 2 on the abort_n-th WRITE.
  task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input int len,
                         input int abort_kind, input int abort_n, input bit dup_start,
                         output int done_cyc, output int re_cnt, output int we_cnt);
    int cyc;
    bit overlap;
    i_src   = src;
    i_dst   = dst;
    i_len   = LEN_W'(len);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cyc = 1; re_cnt = 0; we_cnt = 0; overlap = 1'b0;
    while (!o_done && cyc < 200) begin
      if (o_re) re_cnt++;
      if (o_we) we_cnt++;
      if (o_re && o_we) overlap = 1'b1;
      i_abort = (abort_kind == 1 && o_re && re_cnt == abort_n) ||
                (abort_kind == 2 && o_we && we_cnt == abort_n);
      i_start = dup_start && (cyc == 2);
      tick();
      cyc++;
    end
    i_abort = 1'b0;
    i_start = 1'b0;
    if (o_re) re_cnt++;
    if (o_we) we_cnt++;
    check("re_we_exclusive", {31'h0, overlap}, 32'h0);
    done_cyc = o_done ? cyc : -1;
  endtask

  task automatic finish_cmd(input string tag, input int done_cyc, input int re_cnt, input int we_cnt,
                            input int exp_cyc, input bit exp_err, input int exp_cnt,
                            input int exp_re, input int exp_we);
    check({tag, "_done_cycle"}, done_cyc, exp_cyc);
    check({tag, "_err"},        {31'h0, o_err}, {31'h0, exp_err});
    check({tag, "_count"},      {20'h0, o_count}, exp_cnt);
    check({tag, "_re_cycles"},  re_cnt, exp_re);
    check({tag, "_we_cycles"},  we_cnt, exp_we);
    check({tag, "_busy_done"},  {31'h0, o_busy}, 32'h1);
    tick();
    check({tag, "_busy_after"}, {31'h0, o_busy}, 32'h0);
    check({tag, "_count_hold"}, {20'h0, o_count}, exp_cnt);
  endtask

  initial begin
    int dc, rc, wc;
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_src = 32'h0; i_dst = 32'h0; i_len = '0;
    tb_wr = 1'b0; tb_idx = '0; tb_data = 32'h0; led_red = 32'h0;
`ifdef LSU_COPY_FILL_EN
    i_fill = 1'b0; i_pattern = 32'h0;
`endif
    tick(); tick();
    rst = 1'b0;
    check("rst_busy",  {31'h0, o_busy}, 32'h0);
    check("rst_done",  {31'h0, o_done}, 32'h0);
    check("rst_err",   {31'h0, o_err},  32'h0);
    check("rst_count", {20'h0, o_count}, 32'h0);
    check("rst_re",    {31'h0, o_re},   32'h0);
    check("rst_we",    {31'h0, o_we},   32'h0);
    check("rst_addr",  o_addr,  32'h0);
    check("rst_wdata", o_wdata, 32'h0);

    // Four-word copy
    poke(32'h2000, 32'h1111_1111);
    poke(32'h2004, 32'h2222_2222);
    poke(32'h2008, 32'h3333_3333);
    poke(32'h200C, 32'h4444_4444);
    run_cmd(32'h2000, 32'h2100, 4, 0, 0, 1'b0, dc, rc, wc);
    finish_cmd("copy4", dc, rc, wc, 9, 1'b0, 4, 4, 4);
    check("copy4_w0", peek(32'h2100), 32'h1111_1111);
    check("copy4_w1", peek(32'h2104), 32'h2222_2222);
    check("copy4_w2", peek(32'h2108), 32'h3333_3333);
    check("copy4_w3", peek(32'h210C), 32'h4444_4444);

    // Misaligned source, count cleared by the start
    run_cmd(32'h2002, 32'h2100, 3, 0, 0, 1'b0, dc, rc, wc);
    finish_cmd("misalign", dc, rc, wc, 1, 1'b1, 0, 0, 0);

    // Zero length
    run_cmd(32'h2000, 32'h2100, 0, 0, 0, 1'b0, dc, rc, wc);
    finish_cmd("len0", dc, rc, wc, 1, 1'b0, 0, 0, 0);

    // Abort in 3rd WRITE: that write still lands
    poke(32'h220C, 32'h0);
    run_cmd(32'h2000, 32'h2200, 8, 2, 3, 1'b0, dc, rc, wc);
    finish_cmd("abort_wr", dc, rc, wc, 7, 1'b1, 3, 3, 3);
    check("abort_wr_w2", peek(32'h2208), 32'h3333_3333);
    check("abort_wr_w3", peek(32'h220C), 32'h0);

    // Abort in 3rd READ: only two words written
    poke(32'h2308, 32'h0);
    run_cmd(32'h2000, 32'h2300, 8, 1, 3, 1'b0, dc, rc, wc);
    finish_cmd("abort_rd", dc, rc, wc, 6, 1'b1, 2, 3, 2);
    check("abort_rd_w1", peek(32'h2304), 32'h2222_2222);
    check("abort_rd_w2", peek(32'h2308), 32'h0);

    // Copy into LED register, with a stray start while busy
    poke(32'h2000, 32'h0000_00A5);
    run_cmd(32'h2000, 32'h0000_7000, 1, 0, 0, 1'b1, dc, rc, wc);
    finish_cmd("led", dc, rc, wc, 3, 1'b0, 1, 1, 1);
    check("led_red", led_red, 32'h0000_00A5);

`ifdef LSU_COPY_FILL_EN
    i_fill = 1'b1; i_pattern = 32'hDEAD_BEEF;
    run_cmd(32'h0, 32'h2000, 16, 0, 0, 1'b0, dc, rc, wc);
    i_fill = 1'b0;
    finish_cmd("fill", dc, rc, wc, 17, 1'b0, 16, 0, 16);
    for (int k = 0; k < 16; k++)
      check("fill_word", peek(32'h2000 + 32'(k * 4)), 32'hDEAD_BEEF);
`endif

    // Reset during the 2nd WRITE of a four-word copy
    poke(32'h2108, 32'h0BAD_BEEF);
    i_src = 32'h2000; i_dst = 32'h2100; i_len = LEN_W'(4);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    begin
      int seen_we = 0;
      int guard = 0;
      while (guard < 50) begin
        if (o_we) seen_we++;
        if (seen_we == 2) break;
        tick();
        guard++;
      end
      check("rstmid_reached", seen_we, 2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy",  {31'h0, o_busy}, 32'h0);
    check("rstmid_done",  {31'h0, o_done}, 32'h0);
    check("rstmid_err",   {31'h0, o_err},  32'h0);
    check("rstmid_count", {20'h0, o_count}, 32'h0);
    check("rstmid_re",    {31'h0, o_re},   32'h0);
    check("rstmid_we",    {31'h0, o_we},   32'h0);
    check("rstmid_addr",  o_addr,  32'h0);
    check("rstmid_wdata", o_wdata, 32'h0);
    tick(); tick();
    check("rstmid_idle_we", {31'h0, o_we}, 32'h0);
    check("rstmid_ram",     peek(32'h2108), 32'h0BAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
